// File: rtl/cbi980_axil_slave.sv
// AXI4-Lite slave bridging to a simple strobe-based core register port.
// One outstanding write and one outstanding read; a single FSM serialises core access.
module cbi980_axil_slave #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  output logic [1:0]        s_axil_bresp,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic [2:0]        wr_addr,
  output logic [31:0]       wr_data,
  output logic              wr_en,
  input  logic              wr_err,
  output logic [2:0]        rd_addr,
  output logic              rd_valid_in,
  input  logic [31:0]       rd_data,
  input  logic              rd_valid_out
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_EXEC = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_EXEC = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] RD_RESP = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        rr_q, rr_d;
  logic        aw_full_q, aw_full_d;
  logic [2:0]  aw_addr_q, aw_addr_d;
  logic        w_full_q, w_full_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        ar_full_q, ar_full_d;
  logic [2:0]  ar_addr_q, ar_addr_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic aw_hs, w_hs, ar_hs, wr_elig, rd_elig;
  logic unused_addr_bits;

  assign unused_addr_bits = &{1'b0, s_axil_awaddr, s_axil_araddr};

  assign aw_hs   = s_axil_awvalid & ~aw_full_q;
  assign w_hs    = s_axil_wvalid & ~w_full_q;
  assign ar_hs   = s_axil_arvalid & ~ar_full_q;
  assign wr_elig = aw_full_q & w_full_q;
  assign rd_elig = ar_full_q;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    aw_full_d   = aw_full_q;
    aw_addr_d   = aw_addr_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    ar_full_d   = ar_full_q;
    ar_addr_d   = ar_addr_q;
    bresp_d     = bresp_q;
    rdata_d     = rdata_q;
    wr_en       = 1'b0;
    rd_valid_in = 1'b0;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axil_awaddr[4:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_axil_wdata;
      w_strb_d = s_axil_wstrb;
    end
    if (ar_hs) begin
      ar_full_d = 1'b1;
      ar_addr_d = s_axil_araddr[4:2];
    end

    case (state_q)
      IDLE: begin
        // rr_q only flips on a contested grant; set means read wins the next tie
        if (wr_elig && rd_elig) begin
          state_d = rr_q ? RD_EXEC : WR_EXEC;
          rr_d    = ~rr_q;
        end else if (wr_elig) begin
          state_d = WR_EXEC;
        end else if (rd_elig) begin
          state_d = RD_EXEC;
        end
      end
      WR_EXEC: begin
        wr_en   = (w_strb_q == 4'hF);
        bresp_d = ((w_strb_q != 4'hF) || (wr_en && wr_err)) ? 2'b10 : 2'b00;
        state_d = WR_RESP;
      end
      WR_RESP: begin
        if (s_axil_bready) begin
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      RD_EXEC: begin
        rd_valid_in = 1'b1;
        state_d     = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_valid_out) begin
          rdata_d = rd_data;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (s_axil_rready) begin
          ar_full_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
      bresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_full_q <= ar_full_d;
      ar_addr_q <= ar_addr_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axil_awready = ~aw_full_q;
  assign s_axil_wready  = ~w_full_q;
  assign s_axil_arready = ~ar_full_q;
  assign s_axil_bvalid  = (state_q == WR_RESP);
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = (state_q == RD_RESP);
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = 2'b00;
  // Holding registers are stable while their transaction is live, so they drive the core directly
  assign wr_addr        = aw_addr_q;
  assign wr_data        = w_data_q;
  assign rd_addr        = ar_addr_q;

endmodule
